// File: rtl/sp_ctrl.sv
// Multi-cycle control sequencer for the SP datapath: IDLE->DEC->EXE->(MEM)->WB->DONE.
// Optional `SP_CTRL_ILLEGAL_EN adds an illegal output for opcodes 10..63 and suppresses their PC update.
module sp_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 4,
    parameter int unsigned PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic            rs_eq_rt,
    input  logic            mem_ready,
    input  logic [PC_W-1:0] pc_cur,
    output logic [4:0]      rs_addr,
    output logic [4:0]      rt_addr,
    output logic [4:0]      wb_addr,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic [31:0]     imm_ext,
    output logic [4:0]      shamt,
    output logic            mem_re,
    output logic            mem_we,
    output logic            reg_we,
    output logic            pc_we,
    output logic [PC_W-1:0] pc_next,
    output logic            busy,
    output logic            mem_err,
`ifdef SP_CTRL_ILLEGAL_EN
    output logic            illegal,
`endif
    output logic            out_valid
);

    typedef enum logic [2:0] {IDLE, DEC, EXE, MEM, WB, DONE} state_t;

    state_t            state_q;
    logic [5:0]        op_q;
    logic [4:0]        rs_addr_q, rt_addr_q, wb_addr_q, shamt_q;
    logic [3:0]        alu_op_q;
    logic              alu_src_imm_q;
    logic [31:0]       imm_ext_q;
    logic              mem_re_q, mem_we_q, reg_we_q, pc_we_q;
    logic [PC_W-1:0]   pc_next_q;
    logic              busy_q, mem_err_q, out_valid_q, abort_q;
    logic [2:0]        wait_q;
`ifdef SP_CTRL_ILLEGAL_EN
    logic              illegal_q;
`endif

    logic [3:0]        alu_op_d;
    logic              alu_src_imm_d;
    logic [31:0]       imm_ext_d;
    logic [4:0]        wb_addr_d, shamt_d;
    logic [PC_W-1:0]   pc_seq, pc_br;
    logic              br_taken, exe_reg_we, is_mem, is_illegal;

    // Decode straight from the incoming word so the DEC-state outputs are registered at acceptance.
    always_comb begin
        alu_op_d      = 4'd0;
        alu_src_imm_d = 1'b0;
        case (inst[31:26])
            6'd0: begin
                case (inst[5:0])
                    6'd0:    alu_op_d = 4'd0;
                    6'd1:    alu_op_d = 4'd1;
                    6'd2:    alu_op_d = 4'd2;
                    6'd3:    alu_op_d = 4'd3;
                    6'd4:    alu_op_d = 4'd4;
                    6'd5:    alu_op_d = 4'd5;
                    default: alu_op_d = 4'd6;
                endcase
            end
            6'd1:       begin alu_op_d = 4'd0; alu_src_imm_d = 1'b1; end
            6'd2:       begin alu_op_d = 4'd1; alu_src_imm_d = 1'b1; end
            6'd3, 6'd5,
            6'd6:       begin alu_op_d = 4'd2; alu_src_imm_d = 1'b1; end
            6'd4:       begin alu_op_d = 4'd3; alu_src_imm_d = 1'b1; end
            6'd7, 6'd8: alu_op_d = 4'd3;
            6'd9:       begin alu_op_d = 4'd7; alu_src_imm_d = 1'b1; end
            default:    alu_op_d = 4'd0;
        endcase
        imm_ext_d = (inst[31:26] == 6'd1 || inst[31:26] == 6'd2) ? {16'h0000, inst[15:0]}
                                                                 : {{16{inst[15]}}, inst[15:0]};
        wb_addr_d = (inst[31:26] == 6'd0) ? inst[15:11] : inst[20:16];
        shamt_d   = (inst[31:26] == 6'd0) ? inst[10:6] : 5'd0;
    end

    assign pc_seq     = pc_cur + PC_W'(4);
    assign pc_br      = pc_seq + (PC_W'(imm_ext_q) << 2);
    assign br_taken   = (op_q == 6'd7 && rs_eq_rt) || (op_q == 6'd8 && !rs_eq_rt);
    assign exe_reg_we = (op_q <= 6'd4) || (op_q == 6'd9);
    assign is_mem     = (op_q == 6'd5) || (op_q == 6'd6);
    assign is_illegal = (op_q >= 6'd10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= '0;
            rs_addr_q     <= '0;
            rt_addr_q     <= '0;
            wb_addr_q     <= '0;
            shamt_q       <= '0;
            alu_op_q      <= '0;
            alu_src_imm_q <= 1'b0;
            imm_ext_q     <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            reg_we_q      <= 1'b0;
            pc_we_q       <= 1'b0;
            pc_next_q     <= '0;
            busy_q        <= 1'b0;
            mem_err_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            abort_q       <= 1'b0;
            wait_q        <= '0;
`ifdef SP_CTRL_ILLEGAL_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            reg_we_q    <= 1'b0;
            pc_we_q     <= 1'b0;
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q          <= inst[31:26];
                    rs_addr_q     <= inst[25:21];
                    rt_addr_q     <= inst[20:16];
                    wb_addr_q     <= wb_addr_d;
                    shamt_q       <= shamt_d;
                    alu_op_q      <= alu_op_d;
                    alu_src_imm_q <= alu_src_imm_d;
                    imm_ext_q     <= imm_ext_d;
                    abort_q       <= 1'b0;
                    busy_q        <= 1'b1;
                    state_q       <= DEC;
                end
                DEC: state_q <= EXE;
                EXE: if (is_mem) begin
                    mem_re_q <= (op_q == 6'd5);
                    mem_we_q <= (op_q == 6'd6);
                    wait_q   <= 3'd1;
                    state_q  <= MEM;
                end else begin
                    reg_we_q  <= exe_reg_we;
`ifdef SP_CTRL_ILLEGAL_EN
                    pc_we_q   <= !is_illegal;
`else
                    pc_we_q   <= 1'b1;
`endif
                    pc_next_q <= br_taken ? pc_br : pc_seq;
                    state_q   <= WB;
                end
                // wait_q counts MEM cycles already spent, including the current one.
                MEM: if (mem_ready || wait_q == 3'(MEM_WAIT_MAX)) begin
                    mem_re_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    abort_q   <= !mem_ready;
                    reg_we_q  <= mem_ready && (op_q == 6'd5);
                    pc_we_q   <= 1'b1;
                    pc_next_q <= pc_seq;
                    state_q   <= WB;
                end else begin
                    wait_q <= wait_q + 3'd1;
                end
                WB: begin
                    out_valid_q <= 1'b1;
                    mem_err_q   <= abort_q;
`ifdef SP_CTRL_ILLEGAL_EN
                    illegal_q   <= is_illegal;
`endif
                    state_q     <= DONE;
                end
                DONE: begin
                    busy_q    <= 1'b0;
                    mem_err_q <= 1'b0;
`ifdef SP_CTRL_ILLEGAL_EN
                    illegal_q <= 1'b0;
`endif
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rs_addr     = rs_addr_q;
    assign rt_addr     = rt_addr_q;
    assign wb_addr     = wb_addr_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = alu_src_imm_q;
    assign imm_ext     = imm_ext_q;
    assign shamt       = shamt_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign reg_we      = reg_we_q;
    assign pc_we       = pc_we_q;
    assign pc_next     = pc_next_q;
    assign busy        = busy_q;
    assign mem_err     = mem_err_q;
    assign out_valid   = out_valid_q;
`ifdef SP_CTRL_ILLEGAL_EN
    assign illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_sp_ctrl.sv
// Directed scoreboard bench for sp_ctrl: expectations queued at issue, checked at out_valid.
module tb_sp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, rs_eq_rt, mem_ready;
    logic [31:0] inst, pc_cur;
    logic [4:0]  rs_addr, rt_addr, wb_addr, shamt;
    logic [3:0]  alu_op;
    logic        alu_src_imm, mem_re, mem_we, reg_we, pc_we, busy, mem_err, out_valid;
    logic [31:0] imm_ext, pc_next;
`ifdef SP_CTRL_ILLEGAL_EN
    logic        illegal;
`endif

    sp_ctrl #(.MEM_WAIT_MAX(4), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst), .rs_eq_rt(rs_eq_rt),
        .mem_ready(mem_ready), .pc_cur(pc_cur), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .wb_addr(wb_addr), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
        .shamt(shamt), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_next(pc_next), .busy(busy), .mem_err(mem_err),
`ifdef SP_CTRL_ILLEGAL_EN
        .illegal(illegal),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          lat;
        logic        rwe;
        int          wb;
        int          alu;
        logic [31:0] imm;
        int          sh;
        logic [31:0] pcn;
        logic        err;
        int          mcyc;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wb/alu/sh of -1 mean the field is not architecturally defined for that instruction.
    task automatic run(input logic [31:0] ins, input logic [31:0] pc, input logic eq,
                       input int rdy, input bit intr, input int lat, input logic rwe,
                       input int wb, input int alu, input logic [31:0] imm, input int sh,
                       input logic [31:0] pcn, input logic err, input int mcyc);
        exp_t e;
        bit   done = 1'b0;
        int   mseen = 0;
        logic c_rwe = 1'b0, c_pcwe = 1'b0;
        logic [4:0]  c_wb = '0, c_sh = '0;
        logic [3:0]  c_alu = '0;
        logic [31:0] c_pcn = '0, c_imm = '0;
        e.lat = lat; e.rwe = rwe; e.wb = wb; e.alu = alu; e.imm = imm; e.sh = sh;
        e.pcn = pcn; e.err = err; e.mcyc = mcyc;
        sb.push_back(e);
        pc_cur = pc; rs_eq_rt = eq; inst = ins; in_valid = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 12 && !done; k++) begin
            step();
            in_valid = intr && (k == 2);
            if (in_valid) inst = 32'h2400_1234;
            if (k == 1) begin
                chk("busy_dec", busy, 1'b1);
                chk("rs_addr", rs_addr, ins[25:21]);
                chk("rt_addr", rt_addr, ins[20:16]);
            end
            if (mem_re || mem_we) mseen++;
            if (reg_we || pc_we) begin
                c_rwe = reg_we; c_pcwe = pc_we; c_wb = wb_addr; c_alu = alu_op;
                c_pcn = pc_next; c_imm = imm_ext; c_sh = shamt;
            end
            if (out_valid) begin
                done = 1'b1;
                chk("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("latency", k, e.lat);
                    chk("reg_we", c_rwe, e.rwe);
                    chk("pc_we", c_pcwe, 1'b1);
                    chk("pc_next", c_pcn, e.pcn);
                    chk("imm_ext", c_imm, e.imm);
                    chk("mem_err", mem_err, e.err);
                    chk("mem_cycles", mseen, e.mcyc);
                    chk("busy_done", busy, 1'b1);
                    if (e.wb >= 0)  chk("wb_addr", c_wb, e.wb);
                    if (e.alu >= 0) chk("alu_op", c_alu, e.alu);
                    if (e.sh >= 0)  chk("shamt", c_sh, e.sh);
                end
            end
            mem_ready = (k == rdy);
        end
        chk("completed", done, 1'b1);
        mem_ready = 1'b0;
        step();
        chk("ov_one_cycle", out_valid, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        int   ov_cnt;
        logic bad;
        rst_n = 1'b0; in_valid = 1'b0; inst = '0; rs_eq_rt = 1'b0; mem_ready = 1'b0; pc_cur = '0;
        #12;
        chk("rst_ctrl", {rs_addr, rt_addr, wb_addr, alu_op, alu_src_imm, shamt, mem_re, mem_we,
                         reg_we, pc_we, busy, mem_err, out_valid}, 0);
        chk("rst_imm", imm_ext, 0);
        chk("rst_pc_next", pc_next, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Reset asserted in the EXE cycle of an add.
        inst = 32'h0022_1802; pc_cur = '0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {rs_addr, rt_addr, wb_addr, alu_op, alu_src_imm, shamt, mem_re, mem_we,
                            reg_we, pc_we, busy, mem_err, out_valid}, 0);
        chk("midrst_imm", imm_ext, 0);
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            bad = bad | reg_we | pc_we | mem_re | mem_we | out_valid | busy;
        end
        chk("post_rst_quiet", bad, 1'b0);

        //  ins           pc        eq rdy intr lat rwe wb  alu imm           sh  pcn       err mcyc
        run(32'h0022_1802, 32'h0,   0, 0,  0,   4,  1,  3,  2,  32'h0000_1802, 0,  32'h4,    0,  0); // add
        run(32'h1C22_FFFE, 32'h20,  1, 0,  0,   4,  0, -1,  3,  32'hFFFF_FFFE,-1,  32'h1C,   0,  0); // beq taken
        run(32'h2022_FFFE, 32'h20,  1, 0,  0,   4,  0, -1,  3,  32'hFFFF_FFFE,-1,  32'h24,   0,  0); // bne not taken
        run(32'h2022_0003, 32'h20,  0, 0,  0,   4,  0, -1,  3,  32'h0000_0003,-1,  32'h30,   0,  0); // bne taken
        run(32'h1C22_FFFE, 32'h20,  0, 0,  0,   4,  0, -1,  3,  32'hFFFF_FFFE,-1,  32'h24,   0,  0); // beq not taken
        run(32'h1487_0010, 32'h100, 0, 4,  0,   6,  1,  7,  2,  32'h0000_0010,-1,  32'h104,  0,  2); // lw, ready 2nd MEM
        run(32'h1487_0010, 32'h300, 0, 3,  0,   5,  1,  7,  2,  32'h0000_0010,-1,  32'h304,  0,  1); // lw, ready 1st MEM
        run(32'h18A8_FFFC, 32'h200, 0, 0,  0,   8,  0, -1,  2,  32'hFFFF_FFFC,-1,  32'h204,  1,  4); // sw abort
        run(32'h0429_8000, 32'h40,  0, 0,  0,   4,  1,  9,  0,  32'h0000_8000,-1,  32'h44,   0,  0); // andi
        run(32'h0C4A_8000, 32'h44,  0, 0,  1,   4,  1, 10,  2,  32'hFFFF_8000,-1,  32'h48,   0,  0); // addi + ignored pulse
        ov_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) ov_cnt++;
        end
        chk("ignored_inst", ov_cnt, 0);
        run(32'h0022_20C5, 32'h60,  0, 0,  0,   4,  1,  4,  5,  32'h0000_20C5, 3,  32'h64,   0,  0); // sll
        run(32'h0022_F809, 32'h64,  0, 0,  0,   4,  1, 31,  6,  32'hFFFF_F809, 0,  32'h68,   0,  0); // nor (func 9)
        run(32'h0022_2804, 32'h68,  0, 0,  0,   4,  1,  5,  4,  32'h0000_2804, 0,  32'h6C,   0,  0); // slt
        run(32'h2400_1234, 32'h70,  0, 0,  0,   4,  1,  0,  7,  32'h0000_1234,-1,  32'h74,   0,  0); // lui r0
        run(32'h3064_0005, 32'h80,  0, 0,  0,   4,  0, -1, -1,  32'h0000_0005,-1,  32'h84,   0,  0); // opcode 12 NOP
        run(32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 0, 0, 4, 0, -1, -1, 32'hFFFF_FFFF,-1, 32'h0,    0,  0); // opcode 63, PC wrap
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
